// File: rtl/flash_audio_sequencer.sv
// flash_audio_sequencer: fetches 32-bit PCM words from flash and plays two 16-bit samples per word.
// Define FLASH_AUDIO_MUTE_ON_PAUSE_EN to emit silence (zero samples) while paused.
module flash_audio_sequencer #(
  parameter int ADDR_W = 23,
  parameter logic [ADDR_W-1:0] END_ADDR = 23'h7FFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              forward,
  input  logic              pause,
  input  logic              restart,
  input  logic              sample_tick,
  output logic              flash_read,
  output logic [ADDR_W-1:0] flash_address,
  input  logic              flash_waitrequest,
  input  logic              flash_readdatavalid,
  input  logic [31:0]       flash_readdata,
  output logic [15:0]       audio_sample,
  output logic              sample_valid
);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_PLAY1, S_TICK2, S_PLAY2, S_ADV} state_t;
  state_t r_state, w_next;
  logic [ADDR_W-1:0] r_addr, w_step;
  logic [31:0] r_word;
  logic [15:0] r_sample;
  logic r_dir, r_restart_pending, r_mute_valid, w_go, w_mute;
  assign w_go = sample_tick & ~pause;
  assign w_step = r_dir ? (r_addr == END_ADDR ? '0 : r_addr + 1'b1)
                        : (r_addr == '0 ? END_ADDR : r_addr - 1'b1);
`ifdef FLASH_AUDIO_MUTE_ON_PAUSE_EN
  assign w_mute = pause & (r_state == S_IDLE || r_state == S_TICK2);
`else
  assign w_mute = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    flash_read = 1'b0;
    case (r_state)
      S_IDLE:  w_next = w_go ? S_REQ : S_IDLE;
      S_REQ: begin
        flash_read = 1'b1;
        w_next = flash_waitrequest ? S_REQ : S_WAIT;
      end
      S_WAIT:  w_next = flash_readdatavalid ? S_PLAY1 : S_WAIT;
      S_PLAY1: w_next = S_TICK2;
      S_TICK2: w_next = w_go ? S_PLAY2 : S_TICK2;
      S_PLAY2: w_next = S_ADV;
      default: w_next = S_IDLE;
    endcase
  end
  assign flash_address = r_addr;
  assign audio_sample = w_mute ? 16'h0000 : r_sample;
  assign sample_valid = r_state == S_PLAY1 || r_state == S_PLAY2 || r_mute_valid;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_addr <= '0;
      r_dir <= 1'b0;
      r_restart_pending <= 1'b0;
      r_word <= '0;
      r_sample <= '0;
      r_mute_valid <= 1'b0;
    end else begin
      r_state <= w_next;
      r_mute_valid <= w_mute & sample_tick;
      // a restart arriving in ADVANCE itself is folded into this word boundary
      if (r_state == S_ADV) begin
        r_addr <= (r_restart_pending | restart) ? (r_dir ? '0 : END_ADDR) : w_step;
        r_restart_pending <= 1'b0;
      end else if (restart) begin
        if (r_state == S_IDLE) r_addr <= forward ? '0 : END_ADDR;
        else r_restart_pending <= 1'b1;
      end
      if (r_state == S_IDLE && w_go) r_dir <= forward;
      if (r_state == S_WAIT && flash_readdatavalid) begin
        r_word <= flash_readdata;
        r_sample <= r_dir ? flash_readdata[15:0] : flash_readdata[31:16];
      end
      if (r_state == S_TICK2 && w_go) r_sample <= r_dir ? r_word[31:16] : r_word[15:0];
      if (w_mute) r_sample <= '0;
    end
  end
endmodule

// File: tb/tb_flash_audio_sequencer.sv
// tb_flash_audio_sequencer: directed and randomized playback checked against a word-level model of the song.
module tb_flash_audio_sequencer;
  localparam int END = 3;
`ifdef FLASH_AUDIO_MUTE_ON_PAUSE_EN
  localparam bit MUTE = 1'b1;
`else
  localparam bit MUTE = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, forward = 1'b1, pause = 1'b0, restart = 1'b0, sample_tick = 1'b0;
  logic flash_read, flash_waitrequest, flash_readdatavalid = 1'b0;
  logic [22:0] flash_address;
  logic [31:0] flash_readdata = '0;
  logic [15:0] audio_sample;
  logic sample_valid;
  logic [31:0] mem [0:END];
  int ws_target = 0, lat_target = 1, ws_cnt = 0, lat_cnt = 0, pend_addr = 0;
  bit pend = 1'b0;
  int rd_cycles = 0, addr_glitch = 0, checks = 0, errors = 0, exp_addr = 0;
  logic prev_read = 1'b0;
  logic [22:0] prev_addr = '0;
  logic [22:0] acc_q[$];
  logic [15:0] got_s[$];

  flash_audio_sequencer #(.ADDR_W(23), .END_ADDR(23'd3)) dut (
    .clk(clk), .rst_n(rst_n), .forward(forward), .pause(pause), .restart(restart),
    .sample_tick(sample_tick), .flash_read(flash_read), .flash_address(flash_address),
    .flash_waitrequest(flash_waitrequest), .flash_readdatavalid(flash_readdatavalid),
    .flash_readdata(flash_readdata), .audio_sample(audio_sample), .sample_valid(sample_valid)
  );

  always #5 clk = ~clk;

  // flash slave: ws_target wait states per read, data lat_target cycles after accept
  assign flash_waitrequest = flash_read && ws_cnt < ws_target;
  always @(posedge clk) begin
    flash_readdatavalid <= 1'b0;
    if (flash_read && !flash_waitrequest) begin
      ws_cnt <= 0;
      pend <= 1'b1;
      lat_cnt <= 1;
      pend_addr <= int'(flash_address);
      acc_q.push_back(flash_address);
    end else ws_cnt <= flash_read ? ws_cnt + 1 : 0;
    if (pend) begin
      if (lat_cnt >= lat_target) begin
        flash_readdatavalid <= 1'b1;
        flash_readdata <= mem[pend_addr];
        pend <= 1'b0;
      end else lat_cnt <= lat_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (sample_valid) got_s.push_back(audio_sample);
    if (flash_read) rd_cycles <= rd_cycles + 1;
    if (flash_read && prev_read && flash_address !== prev_addr) addr_glitch <= addr_glitch + 1;
    prev_read <= flash_read;
    prev_addr <= flash_address;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_tick();
    sample_tick = 1'b1;
    @(negedge clk);
    sample_tick = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_samples(input int n, input string tag);
    for (int i = 0; i < 80 && got_s.size() < n; i++) @(negedge clk);
    chk(tag, got_s.size(), n);
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_addr = 0;
  endtask

  // one word: fetch at the model address, two samples in direction order, then step the model
  task automatic play_word(input logic fwd, input int ws, input int lat, input bit rs, input int pt);
    int n0, a0, r0, nz;
    logic [31:0] w;
    n0 = got_s.size();
    a0 = acc_q.size();
    r0 = rd_cycles;
    nz = MUTE ? pt : 0;
    ws_target = ws;
    lat_target = lat;
    forward = fwd;
    w = mem[exp_addr];
    pulse_tick();
    forward = 1'($urandom_range(0, 1));
    if (rs) begin
      for (int i = 0; i < 40 && acc_q.size() == a0; i++) @(negedge clk);
      restart = 1'b1;
      @(negedge clk);
      restart = 1'b0;
    end
    wait_samples(n0 + 1, "first_sample_count");
    @(negedge clk);
    if (pt > 0) begin
      pause = 1'b1;
      repeat (pt) pulse_tick();
      pause = 1'b0;
    end
    pulse_tick();
    wait_samples(n0 + 2 + nz, "second_sample_count");
    repeat (3) @(negedge clk);
    chk("fetch_count", acc_q.size(), a0 + 1);
    if (acc_q.size() > a0) chk("fetch_addr", acc_q[a0], exp_addr);
    chk("read_cycles", rd_cycles - r0, ws + 1);
    if (got_s.size() == n0 + 2 + nz) begin
      chk("first_half", got_s[n0], fwd ? w[15:0] : w[31:16]);
      for (int i = 1; i <= nz; i++) chk("muted_sample", got_s[n0 + i], 0);
      chk("second_half", got_s[n0 + 1 + nz], fwd ? w[31:16] : w[15:0]);
    end
    exp_addr = rs ? (fwd ? 0 : END) : (fwd ? (exp_addr + 1) % (END + 1) : (exp_addr + END) % (END + 1));
  endtask

  initial begin
    int s0, a0, r0;
    logic [15:0] hold;
    int fseq[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int bseq[5] = '{0, 3, 2, 1, 0};
    logic [15:0] fsamp[4] = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};
    mem[0] = 32'hBBBB_AAAA;
    mem[1] = 32'hDDDD_CCCC;
    mem[2] = 32'h2222_1111;
    mem[3] = 32'h4444_3333;
    repeat (2) @(negedge clk);
    chk("reset_read", flash_read, 0);
    chk("reset_addr", flash_address, 0);
    chk("reset_sample", audio_sample, 0);
    chk("reset_valid", sample_valid, 0);
    rst_n = 1'b1;
    @(negedge clk);

    repeat (8) play_word(1'b1, 0, 1, 1'b0, 0);
    if (acc_q.size() >= 8) for (int i = 0; i < 8; i++) chk("fwd_wrap_addr", acc_q[i], fseq[i]);
    if (got_s.size() >= 4) for (int i = 0; i < 4; i++) chk("fwd_sample", got_s[i], fsamp[i]);

    reset_dut();
    s0 = got_s.size();
    a0 = acc_q.size();
    repeat (5) play_word(1'b0, 0, 1, 1'b0, 0);
    if (acc_q.size() >= a0 + 5) for (int i = 0; i < 5; i++) chk("bwd_wrap_addr", acc_q[a0 + i], bseq[i]);
    if (got_s.size() >= s0 + 2) begin
      chk("bwd_word0_first", got_s[s0], 16'hBBBB);
      chk("bwd_word0_second", got_s[s0 + 1], 16'hAAAA);
    end

    s0 = got_s.size();
    a0 = acc_q.size();
    r0 = rd_cycles;
    hold = audio_sample;
    pause = 1'b1;
    repeat (5) pulse_tick();
    repeat (3) @(negedge clk);
    chk("pause_no_read", rd_cycles, r0);
    chk("pause_no_fetch", acc_q.size(), a0);
    chk("pause_valids", got_s.size(), s0 + (MUTE ? 5 : 0));
    chk("pause_sample", audio_sample, MUTE ? 16'h0000 : hold);
    pause = 1'b0;
    play_word(1'b1, 0, 1, 1'b0, 0);

    reset_dut();
    play_word(1'b1, 0, 1, 1'b0, 0);
    play_word(1'b1, 0, 1, 1'b0, 0);
    play_word(1'b1, 0, 2, 1'b1, 0);
    play_word(1'b1, 0, 1, 1'b0, 0);
    play_word(1'b0, 1, 2, 1'b1, 0);
    play_word(1'b1, 0, 1, 1'b0, 0);

    play_word(1'b1, 3, 1, 1'b0, 0);
    play_word(1'b0, 0, 1, 1'b0, 3);

    forward = 1'b0;
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    @(negedge clk);
    exp_addr = END;
    play_word(1'b1, 0, 1, 1'b0, 0);
    play_word(1'b1, 0, 1, 1'b0, 0);

    ws_target = 5;
    forward = 1'b1;
    pulse_tick();
    chk("req_active", flash_read, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_req_read", flash_read, 0);
    chk("rst_req_sample", audio_sample, 0);
    chk("rst_req_addr", flash_address, 0);
    chk("rst_req_valid", sample_valid, 0);
    rst_n = 1'b1;
    ws_target = 0;
    exp_addr = 0;
    @(negedge clk);

    lat_target = 4;
    a0 = acc_q.size();
    pulse_tick();
    for (int i = 0; i < 20 && acc_q.size() == a0; i++) @(negedge clk);
    chk("late_fetch", acc_q.size(), a0 + 1);
    s0 = got_s.size();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("late_data_ignored", got_s.size(), s0);
    chk("late_idle_read", flash_read, 0);
    exp_addr = 0;
    play_word(1'b1, 0, 1, 1'b0, 0);

    for (int k = 0; k < 30; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      play_word(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(1, 3),
                $urandom_range(0, 5) == 0, $urandom_range(0, 2));
    end
    chk("addr_stable_during_wait", addr_glitch, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
